req_encoder16x4: RTL

REQ_ENCODER16X4 -- requirements
Module: req_encoder16x4

---
 rtl/req_encoder16x4_pkg.sv | 13 +
 rtl/req_encoder16x4_prio_enc16x4.sv | 30 +++
 rtl/req_encoder16x4.sv | 85 ++++++++
 3 files changed

// File: rtl/req_encoder16x4_pkg.sv
// Shared types and width constants for the 16-request priority encoder
// and its handshake controller.
package req_encoder16x4_pkg;

  localparam int N_REQ  = 16;
  localparam int CODE_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage : req_encoder16x4_pkg

// File: rtl/req_encoder16x4_prio_enc16x4.sv
// Combinational 16-to-4 priority encoder; HIGH_FIRST selects whether the
// highest or the lowest set bit wins.
module prio_enc16x4
  import req_encoder16x4_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    idx = '0;
    any = |vec;
    if (HIGH_FIRST) begin
      // Ascending scan: the last (highest) set bit overwrites earlier ones.
      for (int i = 0; i < N_REQ; i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
  end

endmodule : prio_enc16x4

// File: rtl/req_encoder16x4.sv
// Collects request pulses into a pending register and presents them one at a
// time as a priority-encoded code under a valid/ack handshake.
module req_encoder16x4
  import req_encoder16x4_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              ack,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  pending,
  output logic              overrun
);

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    pending_q, pending_d;
  logic [CODE_W-1:0]   code_q;
  logic                overrun_q;
  logic [N_REQ-1:0]    clr;
  logic [CODE_W-1:0]   enc_idx;
  logic                enc_any;
  logic                load_code;
  logic                overrun_hit;

  prio_enc16x4 #(
    .HIGH_FIRST(HIGH_FIRST)
  ) u_prio_enc (
    .vec(pending_q),
    .idx(enc_idx),
    .any(enc_any)
  );

  assign valid = (state_q == PRESENT);

  // Clear mask only fires on an accepted handshake; a stray ack is harmless.
  always_comb begin
    clr = '0;
    if (valid && ack) clr[code_q] = 1'b1;
  end

  // OR-ing req after the clear lets a same-cycle re-request survive the ack.
  assign pending_d   = (pending_q & ~clr) | req;
  assign overrun_hit = |(req & pending_q & ~clr);

  always_comb begin
    state_d   = state_q;
    load_code = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d   = PRESENT;
          load_code = 1'b1;
        end
      end
      PRESENT: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (load_code) code_q <= enc_idx;
      if (overrun_hit) overrun_q <= 1'b1;
    end
  end

  assign code    = code_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule : req_encoder16x4
